// File: rtl/wide_compare_sequencer.sv
// Two-requester wide unsigned compare built on one shared 4-bit magnitude comparator.
// Slices are examined MSB first, one per cycle, stopping at the first unequal slice.

module magnitude_comparator (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       gt,
    output logic       lt,
    output logic       eq
);
    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);
endmodule

module wide_compare_sequencer #(
    parameter int NSLICE = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0,
    input  logic [4*NSLICE-1:0]   a0,
    input  logic [4*NSLICE-1:0]   b0,
    input  logic                  req1,
    input  logic [4*NSLICE-1:0]   a1,
    input  logic [4*NSLICE-1:0]   b1,
    output logic                  done0,
    output logic                  done1,
    output logic                  a_gt_b,
    output logic                  a_lt_b,
    output logic                  a_eq_b,
    output logic                  grant_id,
    output logic                  busy,
    output logic [1:0]            fsm_state
);
    localparam int WIDTH = 4 * NSLICE;
    localparam int CW    = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] a_q, b_q;
    logic [CW-1:0]    cnt;
    logic             last_served;
    logic             grant;
    logic             pick;
    logic [3:0]       a_slice, b_slice;
    logic             sl_gt, sl_lt, sl_eq;

    // Slice index is cnt*4; the two low zero bits form the multiply.
    assign a_slice = a_q[{cnt, 2'b00} +: 4];
    assign b_slice = b_q[{cnt, 2'b00} +: 4];

    magnitude_comparator u_cmp (
        .a  (a_slice),
        .b  (b_slice),
        .gt (sl_gt),
        .lt (sl_lt),
        .eq (sl_eq)
    );

    // Round-robin: on a tie, the requester not served last wins.
    assign grant = req0 | req1;
    assign pick  = (req0 && req1) ? ~last_served : req1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (grant) next_state = COMPARE;
            COMPARE: if (!sl_eq || cnt == '0) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q         <= '0;
            b_q         <= '0;
            cnt         <= '0;
            grant_id    <= 1'b0;
            last_served <= 1'b1;
            a_gt_b      <= 1'b0;
            a_lt_b      <= 1'b0;
            a_eq_b      <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        grant_id <= pick;
                        a_q      <= pick ? a1 : a0;
                        b_q      <= pick ? b1 : b0;
                        cnt      <= CW'(NSLICE - 1);
                    end
                end
                COMPARE: begin
                    if (!sl_eq) begin
                        a_gt_b <= sl_gt;
                        a_lt_b <= sl_lt;
                        a_eq_b <= 1'b0;
                    end else if (cnt == '0) begin
                        a_gt_b <= 1'b0;
                        a_lt_b <= 1'b0;
                        a_eq_b <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    done0       <= ~grant_id;
                    done1       <= grant_id;
                    last_served <= grant_id;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_wide_compare_sequencer.sv
// Directed bench for wide_compare_sequencer (NSLICE=4): latency, arbitration, reset abort.
// Inputs change and outputs are sampled 1ns after each rising edge.

module tb_wide_compare_sequencer;
    localparam int NSLICE = 4;
    localparam int W      = 4 * NSLICE;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         done0, done1, a_gt_b, a_lt_b, a_eq_b, grant_id, busy;
    logic [1:0]   fsm_state;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [2:0] R_GT = 3'b100;
    localparam logic [2:0] R_LT = 3'b010;
    localparam logic [2:0] R_EQ = 3'b001;

    wide_compare_sequencer #(.NSLICE(NSLICE)) dut (
        .clock     (clock),
        .reset     (reset),
        .req0      (req0),
        .a0        (a0),
        .b0        (b0),
        .req1      (req1),
        .a1        (a1),
        .b1        (b1),
        .done0     (done0),
        .done1     (done1),
        .a_gt_b    (a_gt_b),
        .a_lt_b    (a_lt_b),
        .a_eq_b    (a_eq_b),
        .grant_id  (grant_id),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Request(s) already raised; E0 grants, k compare cycles, done seen after edge k+1.
    task automatic wait_done(input logic id, input int k, input logic [2:0] res);
        for (int i = 0; i <= k; i++) begin
            tick();
            chk("busy_during", {31'd0, busy}, 32'd1);
            chk("done0_early", {31'd0, done0}, 32'd0);
            chk("done1_early", {31'd0, done1}, 32'd0);
            chk("state_during", {30'd0, fsm_state}, (i < k) ? 32'd1 : 32'd2);
            if (i == 0) chk("grant_id_at_grant", {31'd0, grant_id}, {31'd0, id});
        end
        tick();
        chk("done0_pulse", {31'd0, done0}, {31'd0, ~id});
        chk("done1_pulse", {31'd0, done1}, {31'd0, id});
        chk("result", {29'd0, a_gt_b, a_lt_b, a_eq_b}, {29'd0, res});
        chk("grant_id_at_done", {31'd0, grant_id}, {31'd0, id});
        chk("busy_after", {31'd0, busy}, 32'd0);
        chk("state_after", {30'd0, fsm_state}, 32'd0);
    endtask

    task automatic run_cmp(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int k, input logic [2:0] res);
        if (id) begin a1 = a; b1 = b; req1 = 1'b1; end
        else    begin a0 = a; b0 = b; req0 = 1'b1; end
        wait_done(id, k, res);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        chk("done0_one_cycle", {31'd0, done0}, 32'd0);
        chk("done1_one_cycle", {31'd0, done1}, 32'd0);
        chk("idle_no_req", {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_done0"}, {31'd0, done0}, 32'd0);
        chk({tag, "_done1"}, {31'd0, done1}, 32'd0);
        chk({tag, "_result"}, {29'd0, a_gt_b, a_lt_b, a_eq_b}, 32'd0);
        chk({tag, "_grant_id"}, {31'd0, grant_id}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_state"}, {30'd0, fsm_state}, 32'd0);
    endtask

    initial begin
        tick();
        tick();
        chk_reset_outputs("reset");
        reset = 1'b0;
        tick();
        chk_reset_outputs("post_reset_idle");

        // Equal operands run all four slices; busy high five cycles.
        run_cmp(1'b0, 16'hA5C3, 16'hA5C3, 4, R_EQ);
        // MSB slice decides.
        run_cmp(1'b1, 16'h9000, 16'h8FFF, 1, R_GT);
        // Third slice from the top decides.
        run_cmp(1'b0, 16'h1234, 16'h1244, 3, R_LT);

        // Simultaneous requests after reset: req0 first, then req1.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        a0 = 16'h0001; b0 = 16'h0000;
        a1 = 16'h0000; b1 = 16'h0001;
        req0 = 1'b1; req1 = 1'b1;
        wait_done(1'b0, 4, R_GT);
        req0 = 1'b0;
        wait_done(1'b1, 4, R_LT);
        req1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        wait_done(1'b0, 4, R_GT);
        req0 = 1'b0;
        wait_done(1'b1, 4, R_LT);
        req1 = 1'b0;
        // Operand change after grant must not matter.
        a0 = 16'h7000; b0 = 16'h7000; req0 = 1'b1;
        tick();
        a0 = 16'h0000; b0 = 16'hFFFF;
        for (int i = 0; i < 4; i++) tick();
        tick();
        chk("captured_done0", {31'd0, done0}, 32'd1);
        chk("captured_result", {29'd0, a_gt_b, a_lt_b, a_eq_b}, {29'd0, R_EQ});
        req0 = 1'b0;
        tick();
        // Leave a nonzero result behind before the abort.
        run_cmp(1'b1, 16'h0000, 16'h0001, 4, R_LT);

        // Reset in the 2nd compare cycle aborts with no done.
        a0 = 16'hFFFF; b0 = 16'hFFFF; req0 = 1'b1;
        tick();
        tick();
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        req0 = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk_reset_outputs("abort_async");
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("abort_no_done0", {31'd0, done0}, 32'd0);
            chk("abort_idle", {31'd0, busy}, 32'd0);
        end
        run_cmp(1'b0, 16'hFFFF, 16'hFFFF, 4, R_EQ);

        // req0 held across done0: second compare starts in the IDLE cycle.
        a0 = 16'h0000; b0 = 16'h0000; req0 = 1'b1;
        wait_done(1'b0, 4, R_EQ);
        wait_done(1'b0, 4, R_EQ);
        req0 = 1'b0;
        tick();
        chk("held_done0_drop", {31'd0, done0}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
